// File: rtl/divider_ctrl.sv
// Run/stop and ratio controller for the free-running clock divider counter.
// Optional clk_out toggle output is built when DIVIDER_CTRL_TOGGLE_EN is defined.
module divider_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy
`ifdef DIVIDER_CTRL_TOGGLE_EN
  ,
  output logic             clk_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LP_DEFAULT = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend;
  logic             r_tick;
  logic             r_busy;
  logic             r_cfg_ready;
  logic             r_cfg_err;

  logic w_xfer;
  logic w_div_ok;
  logic w_load;
  logic w_wrap;

  // A ratio transfers when cfg_valid && cfg_ready in the same cycle; a zero
  // ratio still completes the transfer but is rejected with a cfg_err pulse.
  assign w_xfer   = cfg_valid && r_cfg_ready;
  assign w_div_ok = (cfg_div != '0);
  assign w_load   = w_xfer && w_div_ok;
  assign w_wrap   = (r_count == r_div - LP_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_div       <= LP_DEFAULT;
      r_pend      <= '0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !w_div_ok;
      r_tick    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_count     <= '0;
          r_cfg_ready <= 1'b1;
          if (w_load) r_div <= cfg_div;
          if (start && !stop) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // A ratio offered alongside stop loads as if already idle.
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_count     <= '0;
            r_cfg_ready <= 1'b1;
            if (w_load) r_div <= cfg_div;
          end else begin
            if (w_wrap) begin
              r_count <= '0;
              r_tick  <= 1'b1;
            end else begin
              r_count <= r_count + LP_ONE;
            end
            if (w_load) begin
              r_pend      <= cfg_div;
              r_state     <= ST_PEND;
              r_cfg_ready <= 1'b0;
            end
          end
        end
        ST_PEND: begin
          if (stop) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_count     <= '0;
            r_div       <= r_pend;
            r_cfg_ready <= 1'b1;
          end else if (w_wrap) begin
            // The old period completes in full before the new ratio takes over.
            r_count     <= '0;
            r_tick      <= 1'b1;
            r_div       <= r_pend;
            r_state     <= ST_RUN;
            r_cfg_ready <= 1'b1;
          end else begin
            r_count <= r_count + LP_ONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_count     <= '0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DIVIDER_CTRL_TOGGLE_EN
  logic r_clk_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_out <= 1'b0;
    end else if (r_tick) begin
      r_clk_out <= ~r_clk_out;
    end
  end

  assign clk_out = r_clk_out;
`endif

  assign count     = r_count;
  assign tick      = r_tick;
  assign busy      = r_busy;
  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;

endmodule
